// File: rtl/seg7_pkg.sv
// Segment pattern constants and BCD decode shared by the display scanner.
package seg7_pkg;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Codes 10..15 are not valid BCD and are shown as a dash
    function automatic logic [6:0] bcd_to_pattern(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Digit inputs and display pin outputs of the seven-segment scanner.
interface seg7_scan_if #(
    parameter int N_DIG = 4
);
    logic                 enable;
    logic [4*N_DIG-1:0]   bcd_in;
    logic [N_DIG-1:0]     dp_in;
    logic                 blank_lz;
    logic [7:0]           seg_n;
    logic [N_DIG-1:0]     an_n;
    logic                 frame_done;

    modport master (
        output enable, bcd_in, dp_in, blank_lz,
        input  seg_n, an_n, frame_done
    );

    modport slave (
        input  enable, bcd_in, dp_in, blank_lz,
        output seg_n, an_n, frame_done
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high seven-segment decoder.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] pattern_o
);

    assign pattern_o = bcd_to_pattern(code_i);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode display scanner with per-frame snapshot,
// anti-ghost guard, leading-zero blanking and invalid-code dash.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int N_DIG     = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int GHOST_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    seg7_scan_if.slave bus
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIG);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_GHOST = CW'(GHOST_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIG - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [N_DIG-1:0][3:0] shadow_bcd_q, shadow_bcd_d;
    logic [N_DIG-1:0]      shadow_dp_q, shadow_dp_d;
    logic                  frame_done_q, frame_done_d;
    logic [7:0]            seg_q, seg_d;
    logic [N_DIG-1:0]      an_q, an_d;
    logic                  snapshot;
    logic                  above_zero;
    logic [N_DIG-1:0]      lz_blank;
    logic [3:0]            cur_digit;
    logic [6:0]            pattern;

    // Scan FSM, prescaler and digit index; snapshot on scan start and frame wrap
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snapshot     = 1'b0;
        frame_done_d = 1'b0;
        if (!bus.enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (state_q == ST_IDLE) begin
            state_d  = ST_SCAN;
            cnt_d    = '0;
            idx_d    = '0;
            snapshot = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d        = '0;
                snapshot     = 1'b1;
                frame_done_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        shadow_bcd_d = snapshot ? bus.bcd_in : shadow_bcd_q;
        shadow_dp_d  = snapshot ? bus.dp_in  : shadow_dp_q;
    end

    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        above_zero = 1'b1;
        lz_blank   = '0;
        for (int k = N_DIG - 1; k >= 1; k--) begin
            above_zero  = above_zero & (shadow_bcd_q[k] == 4'd0);
            lz_blank[k] = above_zero & bus.blank_lz;
        end
    end

    assign cur_digit = shadow_bcd_q[idx_q];

    bcd_to_seg7 u_dec (
        .code_i    (cur_digit),
        .pattern_o (pattern)
    );

    // Output drive: dark when idle or in the guard window, else one anode low
    always_comb begin
        seg_d = 8'hFF;
        an_d  = '1;
        if (bus.enable && state_q == ST_SCAN && cnt_q >= CNT_GHOST) begin
            an_d  = ~(N_DIG'(1) << idx_q);
            seg_d = {~shadow_dp_q[idx_q], lz_blank[idx_q] ? ~SEG_OFF : ~pattern};
        end
    end

    // State and registered pin outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            frame_done_q <= 1'b0;
            seg_q        <= 8'hFF;
            an_q         <= '1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign bus.seg_n      = seg_q;
    assign bus.an_n       = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with N_DIG=4, SCAN_DIV=8, GHOST_CYC=2.
module tb_seg7_scan;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int GH  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int vecCount  = 0;
    int missCount = 0;

    seg7_scan_if #(.N_DIG(N)) bus ();

    seg7_scan #(
        .N_DIG     (N),
        .SCAN_DIV  (DIV),
        .GHOST_CYC (GH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    logic [3:0] expAn [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, load inputs, then raise enable; returns just after the edge that samples enable
    task automatic restart(input logic [15:0] bcd, input logic [3:0] dp, input logic lz);
        bus.enable = 1'b0;
        rst_n      = 1'b0;
        step();
        rst_n        = 1'b1;
        bus.bcd_in   = bcd;
        bus.dp_in    = dp;
        bus.blank_lz = lz;
        step();
        bus.enable = 1'b1;
        step();
    endtask

    task automatic test_reset();
        bus.enable   = 1'b0;
        bus.bcd_in   = 16'h0000;
        bus.dp_in    = 4'h0;
        bus.blank_lz = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        vecCount++;
        if ({bus.seg_n, bus.an_n, bus.frame_done} !== 13'h1FFE) begin
            missCount++;
            $display("[TB] FAIL reset_async got %h want 1ffe", {bus.seg_n, bus.an_n, bus.frame_done});
        end
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            vecCount++;
            if ({bus.seg_n, bus.an_n, bus.frame_done} !== 13'h1FFE) begin
                missCount++;
                $display("[TB] FAIL reset_idle k=%0d got %h want 1ffe", k, {bus.seg_n, bus.an_n, bus.frame_done});
            end
        end
    endtask

    task automatic test_scan();
        logic [7:0] expSeg [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        restart(16'h1234, 4'h0, 1'b0);
        for (int k = 1; k <= 64; k++) begin
            int c = (k - 1) % DIV;
            int s = ((k - 1) / DIV) % N;
            logic [7:0] wSeg = (c < GH) ? 8'hFF : expSeg[s];
            logic [3:0] wAn  = (c < GH) ? 4'hF : expAn[s];
            logic       wFd  = (k % 32 == 0);
            step();
            vecCount += 3;
            if (bus.seg_n !== wSeg) begin
                missCount++;
                $display("[TB] FAIL scan_seg k=%0d got %h want %h", k, bus.seg_n, wSeg);
            end
            if (bus.an_n !== wAn) begin
                missCount++;
                $display("[TB] FAIL scan_an k=%0d got %h want %h", k, bus.an_n, wAn);
            end
            if (bus.frame_done !== wFd) begin
                missCount++;
                $display("[TB] FAIL scan_frame_done k=%0d got %b want %b", k, bus.frame_done, wFd);
            end
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] expSeg [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        restart(16'h1234, 4'h0, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            int c = (k - 1) % DIV;
            int s = ((k - 1) / DIV) % N;
            logic [7:0] wSeg = (k <= 32) ? expSeg[s] : 8'h90;
            step();
            if (c >= GH) begin
                vecCount++;
                if (bus.seg_n !== wSeg) begin
                    missCount++;
                    $display("[TB] FAIL snapshot_seg k=%0d got %h want %h", k, bus.seg_n, wSeg);
                end
            end
            if (k == 10) bus.bcd_in = 16'h9999;
        end
    endtask

    task automatic test_leading_zero();
        logic [7:0] expLz [4] = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
        logic [7:0] expNo [4] = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
        restart(16'h0050, 4'h0, 1'b1);
        for (int k = 1; k <= 64; k++) begin
            int c = (k - 1) % DIV;
            int s = ((k - 1) / DIV) % N;
            logic [7:0] wSeg = (k <= 32) ? expLz[s] : expNo[s];
            step();
            if (c >= GH) begin
                vecCount += 2;
                if (bus.seg_n !== wSeg) begin
                    missCount++;
                    $display("[TB] FAIL lz_seg k=%0d got %h want %h", k, bus.seg_n, wSeg);
                end
                if (bus.an_n !== expAn[s]) begin
                    missCount++;
                    $display("[TB] FAIL lz_an k=%0d got %h want %h", k, bus.an_n, expAn[s]);
                end
            end
            if (k == 32) bus.blank_lz = 1'b0;
        end
    endtask

    task automatic test_dash_dp();
        logic [7:0] expDash [4] = '{8'h3F, 8'hB0, 8'hA4, 8'hF9};
        logic [7:0] expBlnk [4] = '{8'hC0, 8'hFF, 8'h7F, 8'hFF};
        restart(16'h123A, 4'b0001, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            int c = (k - 1) % DIV;
            int s = ((k - 1) / DIV) % N;
            logic [7:0] wSeg = (c < GH) ? 8'hFF : expDash[s];
            logic [3:0] wAn  = (c < GH) ? 4'hF : expAn[s];
            step();
            vecCount++;
            if ({bus.seg_n, bus.an_n} !== {wSeg, wAn}) begin
                missCount++;
                $display("[TB] FAIL dash_guard k=%0d got %h want %h", k, {bus.seg_n, bus.an_n}, {wSeg, wAn});
            end
        end
        restart(16'h0000, 4'b0100, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            int c = (k - 1) % DIV;
            int s = ((k - 1) / DIV) % N;
            step();
            if (c >= GH) begin
                vecCount++;
                if ({bus.seg_n, bus.an_n} !== {expBlnk[s], expAn[s]}) begin
                    missCount++;
                    $display("[TB] FAIL blank_dp k=%0d got %h want %h", k, {bus.seg_n, bus.an_n}, {expBlnk[s], expAn[s]});
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        restart(16'h1234, 4'h0, 1'b0);
        for (int k = 1; k <= 20; k++) step();
        vecCount++;
        if ({bus.seg_n, bus.an_n} !== 12'hA4B) begin
            missCount++;
            $display("[TB] FAIL drop_before got %h want a4b", {bus.seg_n, bus.an_n});
        end
        bus.enable = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            step();
            vecCount++;
            if ({bus.seg_n, bus.an_n, bus.frame_done} !== 13'h1FFE) begin
                missCount++;
                $display("[TB] FAIL drop_dark j=%0d got %h want 1ffe", j, {bus.seg_n, bus.an_n, bus.frame_done});
            end
        end
        bus.enable = 1'b1;
        step();
        for (int k = 1; k <= DIV; k++) begin
            logic [11:0] want = (k <= GH) ? 12'hFFF : 12'h99E;
            step();
            vecCount++;
            if ({bus.seg_n, bus.an_n} !== want) begin
                missCount++;
                $display("[TB] FAIL drop_resume k=%0d got %h want %h", k, {bus.seg_n, bus.an_n}, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        restart(16'h1234, 4'h0, 1'b0);
        for (int k = 1; k <= 12; k++) step();
        vecCount++;
        if ({bus.seg_n, bus.an_n} !== 12'hB0D) begin
            missCount++;
            $display("[TB] FAIL rstmid_before got %h want b0d", {bus.seg_n, bus.an_n});
        end
        #2;
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        #1;
        vecCount++;
        if ({bus.seg_n, bus.an_n, bus.frame_done} !== 13'h1FFE) begin
            missCount++;
            $display("[TB] FAIL rstmid_async got %h want 1ffe", {bus.seg_n, bus.an_n, bus.frame_done});
        end
        step();
        step();
        rst_n      = 1'b1;
        bus.bcd_in = 16'h5678;
        for (int j = 1; j <= 10; j++) begin
            step();
            vecCount++;
            if ({bus.seg_n, bus.an_n, bus.frame_done} !== 13'h1FFE) begin
                missCount++;
                $display("[TB] FAIL rstmid_idle j=%0d got %h want 1ffe", j, {bus.seg_n, bus.an_n, bus.frame_done});
            end
        end
        bus.enable = 1'b1;
        step();
        for (int k = 1; k <= DIV; k++) begin
            logic [11:0] want = (k <= GH) ? 12'hFFF : 12'h80E;
            step();
            vecCount++;
            if ({bus.seg_n, bus.an_n} !== want) begin
                missCount++;
                $display("[TB] FAIL rstmid_resume k=%0d got %h want %h", k, {bus.seg_n, bus.an_n}, want);
            end
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_leading_zero();
        test_dash_dp();
        test_enable_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
